score_column_tx: RTL and testbench

Transmit side of the column-per-cycle score interface. Captures a full N×N matrix of 2-bit scores on a start handshake, then streams it out one column per cycle as `data_out` rows with a one-hot `data_valid` column select. The output port set drives the matrix-capture receiver directly, so the receiver's `done` rises on the cycle after this block emits its last column. Supports back-pressure-free pausing (`hold`), optional inter-column gaps, and abort.

---
 rtl/scoring_pkg.sv | 14 +
 rtl/score_column_tx_if.sv | 27 ++
 rtl/score_col_mux.sv | 22 ++
 rtl/score_column_tx.sv | 127 ++++++++++++
 tb/tb_score_column_tx.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scoring_pkg.sv
// Shared types for the column-per-cycle score link (transmitter and receiver).
package scoring_pkg;

   typedef logic [1:0] score_t;

   localparam int SCORE_N = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } tx_state_e;

endpackage

// File: rtl/score_column_tx_if.sv
// Control, snapshot input and column-stream output of score_column_tx as one bundle.
interface score_column_tx_if
   import scoring_pkg::score_t, scoring_pkg::SCORE_N;
#(
   parameter int N = SCORE_N
) ();

   logic                  start;
   logic                  hold;
   logic                  abort;
   score_t [N-1:0][N-1:0] matrix_in;
   score_t [N-1:0]        data_out;
   logic   [N-1:0]        data_valid;
   logic                  busy;
   logic                  sent;

   modport master (
      output start, hold, abort, matrix_in,
      input  data_out, data_valid, busy, sent
   );

   modport slave (
      input  start, hold, abort, matrix_in,
      output data_out, data_valid, busy, sent
   );

endinterface

// File: rtl/score_col_mux.sv
// Picks one column out of an NxN score matrix and one-hot encodes its index.
module score_col_mux
   import scoring_pkg::score_t, scoring_pkg::SCORE_N;
#(
   parameter int N  = SCORE_N,
   parameter int CW = $clog2(N)
) (
   input  score_t [N-1:0][N-1:0] matrix,
   input  logic   [CW-1:0]       col,
   output score_t [N-1:0]        column,
   output logic   [N-1:0]        onehot
);

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_row
         assign column[gi] = matrix[gi][col];
         assign onehot[gi] = (col == CW'(gi));
      end
   endgenerate

endmodule

// File: rtl/score_column_tx.sv
// Transmit side of the column-per-cycle score link: snapshots an NxN score matrix on
// start and streams it one column per cycle with a one-hot column select.
module score_column_tx
   import scoring_pkg::score_t, scoring_pkg::SCORE_N;
#(
   parameter int N   = SCORE_N,
   parameter int GAP = 0
) (
   input logic              clk,
   input logic              rst_n,
   score_column_tx_if.slave bus
);

   localparam int         CW       = $clog2(N);
   localparam logic [1:0] ST_IDLE  = 2'(scoring_pkg::IDLE);
   localparam logic [1:0] ST_SEND  = 2'(scoring_pkg::SEND);
   localparam logic [1:0] ST_GAP   = 2'(scoring_pkg::GAP);
   localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   logic [1:0]            state_reg, state_next;
   logic [CW-1:0]         col_reg, col_next;
   logic [3:0]            gap_cnt_reg, gap_cnt_next;
   score_t [N-1:0][N-1:0] snap_reg, snap_next;
   score_t [N-1:0]        data_out_reg, data_out_next;
   logic [N-1:0]          data_valid_reg, data_valid_next;
   logic                  busy_reg, busy_next;
   logic                  sent_reg, sent_next;

   logic                  accept;
   logic                  emit;
   score_t [N-1:0][N-1:0] mux_matrix;
   logic [CW-1:0]         mux_col;
   score_t [N-1:0]        mux_column;
   logic [N-1:0]          mux_onehot;

   // Column 0 leaves on the accepting edge itself, so the mux reads matrix_in directly then.
   assign accept     = (state_reg == ST_IDLE) && bus.start && !bus.abort;
   assign emit       = !bus.abort && !bus.hold && (accept || (state_reg == ST_SEND));
   assign mux_matrix = accept ? bus.matrix_in : snap_reg;
   assign mux_col    = accept ? '0 : col_reg;

   score_col_mux #(
      .N  (N),
      .CW (CW)
   ) u_col_mux (
      .matrix (mux_matrix),
      .col    (mux_col),
      .column (mux_column),
      .onehot (mux_onehot)
   );

   always_comb begin
      state_next      = state_reg;
      col_next        = col_reg;
      gap_cnt_next    = gap_cnt_reg;
      snap_next       = snap_reg;
      sent_next       = sent_reg;
      data_out_next   = '0;
      data_valid_next = '0;

      if (bus.abort) begin
         state_next = ST_IDLE;
         col_next   = '0;
         sent_next  = 1'b0;
      end else begin
         if (accept) begin
            snap_next  = bus.matrix_in;
            col_next   = '0;
            sent_next  = 1'b0;
            state_next = ST_SEND;
         end
         if (emit) begin
            data_valid_next = mux_onehot;
            data_out_next   = mux_column;
            if (mux_col == CW'(N - 1)) begin
               state_next = ST_IDLE;
               sent_next  = 1'b1;
            end else begin
               col_next = mux_col + CW'(1);
               if (GAP > 0) begin
                  state_next   = ST_GAP;
                  gap_cnt_next = GAP_LOAD;
               end else begin
                  state_next = ST_SEND;
               end
            end
         end
         if ((state_reg == ST_GAP) && !bus.hold) begin
            if (gap_cnt_reg == 4'd0) begin
               state_next = ST_SEND;
            end else begin
               gap_cnt_next = gap_cnt_reg - 4'd1;
            end
         end
      end

      busy_next = (state_next != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         col_reg        <= '0;
         gap_cnt_reg    <= '0;
         snap_reg       <= '0;
         data_out_reg   <= '0;
         data_valid_reg <= '0;
         busy_reg       <= 1'b0;
         sent_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         col_reg        <= col_next;
         gap_cnt_reg    <= gap_cnt_next;
         snap_reg       <= snap_next;
         data_out_reg   <= data_out_next;
         data_valid_reg <= data_valid_next;
         busy_reg       <= busy_next;
         sent_reg       <= sent_next;
      end
   end

   assign bus.data_out   = data_out_reg;
   assign bus.data_valid = data_valid_reg;
   assign bus.busy       = busy_reg;
   assign bus.sent       = sent_reg;

endmodule

// File: tb/tb_score_column_tx.sv
// Bench for score_column_tx: GAP=0 and GAP=2 instances driven in lockstep and compared
// every cycle against a token-queue model, plus timing vectors and directed corner cases.
module tb_score_column_tx;
   import scoring_pkg::score_t, scoring_pkg::SCORE_N;

   localparam int N    = SCORE_N;
   localparam int MAXT = N * 16;

   typedef score_t [N-1:0][N-1:0] mat_t;
   typedef score_t [N-1:0]        col_t;

   typedef struct {
      int hold_at;
      int hold_len;
      int exp_last0;
      int exp_last2;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic hold  = 1'b0;
   logic abort = 1'b0;
   mat_t matrix = '0;

   always #5 clk = ~clk;

   score_column_tx_if #(.N(N)) if0 ();
   score_column_tx_if #(.N(N)) if2 ();

   assign if0.start = start;
   assign if0.hold = hold;
   assign if0.abort = abort;
   assign if0.matrix_in = matrix;
   assign if2.start = start;
   assign if2.hold = hold;
   assign if2.abort = abort;
   assign if2.matrix_in = matrix;

   score_column_tx #(.N(N), .GAP(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   score_column_tx #(.N(N), .GAP(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   logic [N-1:0] act_dv [2];
   col_t         act_do [2];
   logic         act_busy [2];
   logic         act_sent [2];

   assign act_dv[0] = if0.data_valid;
   assign act_do[0] = if0.data_out;
   assign act_busy[0] = if0.busy;
   assign act_sent[0] = if0.sent;
   assign act_dv[1] = if2.data_valid;
   assign act_do[1] = if2.data_out;
   assign act_busy[1] = if2.busy;
   assign act_sent[1] = if2.sent;

   // Model: a round is a list of tokens (column index, or -1 for a gap cycle);
   // each non-hold edge consumes one token and shows it on the outputs.
   int           tok [2][MAXT];
   int           head [2];
   int           tail [2];
   mat_t         snap_m [2];
   logic [N-1:0] exp_dv [2];
   col_t         exp_do [2];
   logic         exp_busy [2];
   logic         exp_sent [2];

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   mat_t cap [2];
   int   last_seen [2];
   int   sent_first [2];
   vec_t vecs [5];
   int   t0;
   mat_t m1, m2;
   col_t c0;

   task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s inst=%0d cyc=%0d actual=%0h required=%0h", name, i, cyc, act, req);
      end
   endtask

   task automatic model_reset(input int i);
      head[i] = 0;
      tail[i] = 0;
      snap_m[i] = '0;
      exp_dv[i] = '0;
      exp_do[i] = '0;
      exp_busy[i] = 1'b0;
      exp_sent[i] = 1'b0;
   endtask

   task automatic push(input int i, input int v);
      tok[i][tail[i]] = v;
      tail[i]++;
   endtask

   task automatic model_edge(input int i, input int g);
      int k;
      exp_dv[i] = '0;
      exp_do[i] = '0;
      if (!rst_n) begin
         model_reset(i);
         return;
      end
      if (abort) begin
         head[i] = 0;
         tail[i] = 0;
         exp_sent[i] = 1'b0;
      end else begin
         if ((head[i] == tail[i]) && start) begin
            snap_m[i] = matrix;
            exp_sent[i] = 1'b0;
            head[i] = 0;
            tail[i] = 0;
            for (int c = 0; c < N; c++) begin
               if (c > 0) for (int j = 0; j < g; j++) push(i, -1);
               push(i, c);
            end
         end
         if ((head[i] < tail[i]) && !hold) begin
            k = tok[i][head[i]];
            head[i]++;
            if (k >= 0) begin
               exp_dv[i][k] = 1'b1;
               for (int r = 0; r < N; r++) exp_do[i][r] = snap_m[i][r][k];
               if (k == N - 1) begin
                  exp_sent[i] = 1'b1;
                  $display("round done inst=%0d cyc=%0d", i, cyc);
               end
            end
         end
      end
      exp_busy[i] = (head[i] < tail[i]);
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         chk("data_valid", i, 64'(act_dv[i]), 64'(exp_dv[i]));
         chk("data_out", i, 64'(act_do[i]), 64'(exp_do[i]));
         chk("busy", i, 64'(act_busy[i]), 64'(exp_busy[i]));
         chk("sent", i, 64'(act_sent[i]), 64'(exp_sent[i]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_edge(0, 0);
      model_edge(1, 2);
      #1;
      check_all();
      for (int i = 0; i < 2; i++) begin
         for (int c = 0; c < N; c++)
            if (act_dv[i][c]) for (int r = 0; r < N; r++) cap[i][r][c] = act_do[i][r];
         if (act_dv[i][N-1]) last_seen[i] = cyc;
         if (act_sent[i] && (sent_first[i] < 0)) sent_first[i] = cyc;
      end
   endtask

   task automatic rand_matrix(output mat_t m);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) m[r][c] = score_t'($urandom_range(0, 3));
   endtask

   initial begin
      // {hold_at edge, hold length, last-column cycle for GAP=0, same for GAP=2}
      vecs[0] = '{0, 0, 10, 28};
      vecs[1] = '{2, 3, 13, 31};
      vecs[2] = '{0, 2, 12, 30};
      vecs[3] = '{9, 1, 11, 29};
      vecs[4] = '{12, 4, 10, 32};

      model_reset(0);
      model_reset(1);
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 5; v++) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) matrix[r][c] = score_t'((r + c + v) % 4);
         cap[0] = '0;
         cap[1] = '0;
         for (int e = 0; e < 40; e++) begin
            start = (e == 0);
            hold = (e >= vecs[v].hold_at) && (e < vecs[v].hold_at + vecs[v].hold_len);
            tick();
            if (e == 0) begin
               t0 = cyc;
               for (int i = 0; i < 2; i++) begin
                  last_seen[i] = -1;
                  sent_first[i] = -1;
               end
            end
         end
         hold = 1'b0;
         chk("last_col_cycle", 0, 64'(last_seen[0] - t0 + 1), 64'(vecs[v].exp_last0));
         chk("last_col_cycle", 1, 64'(last_seen[1] - t0 + 1), 64'(vecs[v].exp_last2));
         chk("sent_cycle", 0, 64'(sent_first[0] - t0 + 1), 64'(vecs[v].exp_last0));
         chk("sent_cycle", 1, 64'(sent_first[1] - t0 + 1), 64'(vecs[v].exp_last2));
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (cap[i] !== matrix) begin
               failures++;
               $display("FAIL capture inst=%0d actual=%0h required=%0h", i, cap[i], matrix);
            end
         end
         $display("vector %0d hold_at=%0d hold_len=%0d last0=%0d last2=%0d", v,
                  vecs[v].hold_at, vecs[v].hold_len, last_seen[0] - t0 + 1, last_seen[1] - t0 + 1);
      end

      // Start during a round is ignored; start on the cycle sent rises begins a new round.
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) m1[r][c] = score_t'((3 * r + c) % 4);
      rand_matrix(m2);
      m2[0][0] = ~m1[0][0];
      for (int r = 0; r < N; r++) c0[r] = m2[r][0];
      cap[0] = '0;
      for (int e = 0; e < 40; e++) begin
         start = (e == 0) || (e == 4) || (e == 10);
         matrix = (e == 0) ? m1 : m2;
         tick();
         if (e == 9) begin
            checks++;
            if (cap[0] !== m1) begin
               failures++;
               $display("FAIL ignored_start_capture inst=0 actual=%0h required=%0h", cap[0], m1);
            end
         end
         if (e == 10) begin
            chk("b2b_sent", 0, 64'(act_sent[0]), 64'(0));
            chk("b2b_valid", 0, 64'(act_dv[0]), 64'(1));
            chk("b2b_col0", 0, 64'(act_do[0]), 64'(c0));
         end
      end
      start = 1'b0;
      $display("sequence back_to_back done cyc=%0d", cyc);

      // Abort on the same edge as start and hold.
      rand_matrix(matrix);
      for (int e = 0; e < 21; e++) begin
         start = (e == 0) || (e == 5);
         hold = (e == 5);
         abort = (e == 5);
         tick();
         if (e == 5) begin
            for (int i = 0; i < 2; i++) begin
               chk("abort_valid", i, 64'(act_dv[i]), 64'(0));
               chk("abort_busy", i, 64'(act_busy[i]), 64'(0));
               chk("abort_sent", i, 64'(act_sent[i]), 64'(0));
            end
         end else if (e > 5) begin
            for (int i = 0; i < 2; i++) chk("after_abort_valid", i, 64'(act_dv[i]), 64'(0));
         end
      end
      start = 1'b0;
      hold = 1'b0;
      abort = 1'b0;
      $display("sequence abort done cyc=%0d", cyc);

      // Asynchronous reset mid-round.
      rand_matrix(matrix);
      for (int e = 0; e < 4; e++) begin
         start = (e == 0);
         tick();
      end
      start = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("async_rst_valid", i, 64'(act_dv[i]), 64'(0));
         chk("async_rst_data", i, 64'(act_do[i]), 64'(0));
         chk("async_rst_busy", i, 64'(act_busy[i]), 64'(0));
         model_reset(i);
      end
      tick();
      tick();
      rst_n = 1'b1;
      for (int e = 0; e < 10; e++) begin
         tick();
         for (int i = 0; i < 2; i++) chk("after_rst_valid", i, 64'(act_dv[i]), 64'(0));
      end
      $display("sequence async_reset done cyc=%0d", cyc);

      // Random traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         start = ($urandom_range(0, 7) == 0);
         hold = ($urandom_range(0, 4) == 0);
         abort = ($urandom_range(0, 59) == 0);
         if (start) rand_matrix(matrix);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
